// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives imem and the gshare predictor, and fills IF/ID through a
// one-entry skid buffer. Define FETCH_PERF_CNT_EN to add fetch/bubble/redirect counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int unsigned BTB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              bp_pc,
    output logic [31:0]              bp_pc_4,
    input  logic [31:0]              bp_pc_predicted,
    input  logic [BTB_IDX_WIDTH-1:0] bp_pht_idx,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     IF_ID_valid,
    output logic [31:0]              IF_ID_inst,
    output logic [31:0]              IF_ID_pc,
    output logic [31:0]              IF_ID_pred_target,
    output logic [BTB_IDX_WIDTH-1:0] IF_ID_pht_idx
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_bubble_cnt,
    output logic [31:0]              perf_redirect_cnt
`endif
);

    typedef enum logic [0:0] {StFetch, StKill} state_e;

    typedef struct packed {
        logic [31:0]              inst;
        logic [31:0]              pc;
        logic [31:0]              tgt;
        logic [BTB_IDX_WIDTH-1:0] idx;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        skid_full_q, skid_full_d;
    entry_t      skid_q, skid_d;
    logic        if_id_valid_q, if_id_valid_d;
    entry_t      if_id_q, if_id_d;

    logic        accept;
    entry_t      fetch_entry;

    // Request/address mux: KILL keeps re-presenting the abandoned address until imem completes.
    always_comb begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
        unique case (state_q)
            StFetch: begin
                imem_req  = !skid_full_q;
                imem_addr = pc_q;
            end
            StKill: begin
                imem_req  = 1'b1;
                imem_addr = kill_addr_q;
            end
            default: ;
        endcase
    end

    assign bp_pc   = pc_q;
    assign bp_pc_4 = pc_q + 32'd4;

    assign accept = (state_q == StFetch) && imem_req && imem_ready;

    assign fetch_entry = '{
        inst: imem_rdata,
        pc:   pc_q,
        tgt:  bp_pc_predicted,
        idx:  bp_pht_idx
    };

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_addr_d   = kill_addr_q;
        skid_full_d   = skid_full_q;
        skid_d        = skid_q;
        if_id_valid_d = if_id_valid_q;
        if_id_d       = if_id_q;

        if (state_q == StKill && imem_ready) begin
            state_d = StFetch;
        end

        if (redirect) begin
            pc_d          = redirect_pc;
            if_id_valid_d = 1'b0;
            skid_full_d   = 1'b0;
            // An uncompleted request must still be drained; its data is thrown away in KILL.
            if (state_q == StFetch && imem_req && !imem_ready) begin
                kill_addr_d = pc_q;
                state_d     = StKill;
            end
        end else begin
            if (accept) begin
                pc_d = bp_pc_predicted;
            end
            if (!stall) begin
                if (skid_full_q) begin
                    if_id_d       = skid_q;
                    if_id_valid_d = 1'b1;
                    skid_full_d   = 1'b0;
                end else if (accept) begin
                    if_id_d       = fetch_entry;
                    if_id_valid_d = 1'b1;
                end else begin
                    if_id_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d      = fetch_entry;
                skid_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            kill_addr_q   <= 32'h0;
            skid_full_q   <= 1'b0;
            skid_q        <= '0;
            if_id_valid_q <= 1'b0;
            if_id_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_addr_q   <= kill_addr_d;
            skid_full_q   <= skid_full_d;
            skid_q        <= skid_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_q       <= if_id_d;
        end
    end

    assign IF_ID_valid       = if_id_valid_q;
    assign IF_ID_inst        = if_id_q.inst;
    assign IF_ID_pc          = if_id_q.pc;
    assign IF_ID_pred_target = if_id_q.tgt;
    assign IF_ID_pht_idx     = if_id_q.idx;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q    <= 32'h0;
            bubble_cnt_q   <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!stall && !if_id_valid_d) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (redirect) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_bubble_cnt   = bubble_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model (PC, in-flight entry list, kill flag, IF/ID slot).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam int unsigned W      = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready = 1'b0;
    logic [31:0]   imem_rdata;
    logic [31:0]   bp_pc, bp_pc_4, bp_pc_predicted;
    logic [W-1:0]  bp_pht_idx;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          IF_ID_valid;
    logic [31:0]   IF_ID_inst, IF_ID_pc, IF_ID_pred_target;
    logic [W-1:0]  IF_ID_pht_idx;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt, perf_bubble_cnt, perf_redirect_cnt;
`endif

    int            pred_mode = 0;
    logic [31:0]   jump_from = 32'h0;
    logic [31:0]   jump_to = 32'h0;
    int            n_cmp = 0;
    int            n_fail = 0;

    fetch_stage #(.RESET_PC(RST_PC), .BTB_IDX_WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .bp_pc             (bp_pc),
        .bp_pc_4           (bp_pc_4),
        .bp_pc_predicted   (bp_pc_predicted),
        .bp_pht_idx        (bp_pht_idx),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .IF_ID_valid       (IF_ID_valid),
        .IF_ID_inst        (IF_ID_inst),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_pred_target (IF_ID_pred_target),
        .IF_ID_pht_idx     (IF_ID_pht_idx)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [W-1:0] pht_fn(input logic [31:0] a);
        return a[6:2] ^ a[11:7];
    endfunction

    function automatic logic [31:0] pred_fn(input logic [31:0] a, input int mode,
                                            input logic [31:0] from, input logic [31:0] to);
        if (mode == 1 && a == from) return to;
        if (mode == 2 && a[5:2] == 4'hB) return a ^ 32'h0000_0340;
        return a + 32'd4;
    endfunction

    assign imem_rdata      = mem_fn(imem_addr);
    assign bp_pht_idx      = pht_fn(bp_pc);
    assign bp_pc_predicted = pred_fn(bp_pc, pred_mode, jump_from, jump_to);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 with reset released.
    task automatic do_reset();
        imem_ready  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        reset       = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || bp_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_fetch: req=%b addr=%h bp_pc=%h, want req=1 addr=bp_pc=%h",
                     imem_req, imem_addr, bp_pc, RST_PC);
        end
        n_cmp++;
        if (bp_pc_4 !== RST_PC + 32'd4) begin
            n_fail++;
            $display("FAIL reset_pc4: got %h want %h", bp_pc_4, RST_PC + 32'd4);
        end
        n_cmp++;
        if (IF_ID_valid !== 1'b0 || IF_ID_inst !== 32'h0 || IF_ID_pc !== 32'h0 ||
            IF_ID_pred_target !== 32'h0 || IF_ID_pht_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_ifid: v=%b inst=%h pc=%h tgt=%h idx=%h, want all zero",
                     IF_ID_valid, IF_ID_inst, IF_ID_pc, IF_ID_pred_target, IF_ID_pht_idx);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        pred_mode = 0;
        do_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_addr !== 32'(4 * k) || imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr[%0d]: got %h req=%b want %h req=1",
                         k, imem_addr, imem_req, 32'(4 * k));
            end
            if (k >= 1) begin
                n_cmp++;
                if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'(4 * (k - 1)) ||
                    IF_ID_inst !== mem_fn(32'(4 * (k - 1)))) begin
                    n_fail++;
                    $display("FAIL seq_ifid[%0d]: v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             k, IF_ID_valid, IF_ID_pc, IF_ID_inst, 32'(4 * (k - 1)),
                             mem_fn(32'(4 * (k - 1))));
                end
            end
            tick();
        end
    endtask

    task automatic test_predict();
        pred_mode = 1;
        jump_from = 32'h8;
        jump_to   = 32'h40;
        do_reset();
        imem_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL predict_addr: got %h want 00000040", imem_addr);
        end
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h8 || IF_ID_pred_target !== 32'h40 ||
            IF_ID_pht_idx !== pht_fn(32'h8)) begin
            n_fail++;
            $display("FAIL predict_ifid: v=%b pc=%h tgt=%h idx=%h want 1 8 40 %h",
                     IF_ID_valid, IF_ID_pc, IF_ID_pred_target, IF_ID_pht_idx, pht_fn(32'h8));
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (IF_ID_pc !== 32'h40 || imem_addr !== 32'h44) begin
            n_fail++;
            $display("FAIL predict_follow: ifid_pc=%h addr=%h want 40 44", IF_ID_pc, imem_addr);
        end
        tick();
        pred_mode = 0;
    endtask

    task automatic test_stall_skid();
        pred_mode = 0;
        do_reset();
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%b pc=%h want 1 0", k, IF_ID_valid, IF_ID_pc);
            end
            if (k >= 2) begin
                n_cmp++;
                if (imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req);
                end
            end
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0 || IF_ID_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_drop: req=%b pc=%h want 0 0", imem_req, IF_ID_pc);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h4 || IF_ID_inst !== mem_fn(32'h4) ||
            imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL skid_drain: v=%b pc=%h req=%b addr=%h want 1 4 1 8",
                     IF_ID_valid, IF_ID_pc, imem_req, imem_addr);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL skid_next: v=%b pc=%h want 1 8", IF_ID_valid, IF_ID_pc);
        end
        tick();
    endtask

    // Cycles 0..4 of the kill scenario; leaves the bench at the start of cycle 5 (in KILL).
    task automatic drive_to_kill(input bit check);
        pred_mode = 0;
        do_reset();
        imem_ready = 1'b1;
        repeat (4) tick();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        if (check) begin
            n_cmp++;
            if (imem_addr !== 32'h10 || IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'hC) begin
                n_fail++;
                $display("FAIL kill_pre: addr=%h v=%b pc=%h want 10 1 c",
                         imem_addr, IF_ID_valid, IF_ID_pc);
            end
        end
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_redirect_kill();
        drive_to_kill(1'b1);
        for (int k = 5; k <= 6; k++) begin
            imem_ready = (k == 6);
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || IF_ID_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL kill_hold[%0d]: req=%b addr=%h v=%b want 1 10 0",
                         k, imem_req, imem_addr, IF_ID_valid);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || IF_ID_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_exit: req=%b addr=%h v=%b want 1 80 0",
                     imem_req, imem_addr, IF_ID_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h80 || IF_ID_inst !== mem_fn(32'h80)) begin
            n_fail++;
            $display("FAIL kill_target: v=%b pc=%h inst=%h want 1 80 %h",
                     IF_ID_valid, IF_ID_pc, IF_ID_inst, mem_fn(32'h80));
        end
        tick();
    endtask

    task automatic test_redirect_stall();
        pred_mode = 0;
        do_reset();
        imem_ready = 1'b1;
        tick();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (IF_ID_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_stall: v=%b addr=%h req=%b want 0 200 1",
                     IF_ID_valid, imem_addr, imem_req);
        end
        tick();
        stall = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_stall_after: v=%b pc=%h want 1 200", IF_ID_valid, IF_ID_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid_kill();
        drive_to_kill(1'b0);
        imem_ready = 1'b0;
        #2;
        n_cmp++;
        if (imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL midkill_pre: addr=%h want 10", imem_addr);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || IF_ID_valid !== 1'b0 ||
            IF_ID_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL midkill_reset: req=%b addr=%h v=%b pc=%h want 1 %h 0 0",
                     imem_req, imem_addr, IF_ID_valid, IF_ID_pc, RST_PC);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0 ||
            perf_redirect_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL midkill_perf: %h %h %h want 0 0 0",
                     perf_fetch_cnt, perf_bubble_cnt, perf_redirect_cnt);
        end
`endif
        do_reset();
    endtask

    typedef struct {
        logic [31:0]  inst;
        logic [31:0]  pc;
        logic [31:0]  tgt;
        logic [W-1:0] idx;
    } entry_t;

    task automatic test_random();
        logic [31:0] m_pc;
        bit          m_kill;
        logic [31:0] m_kill_addr;
        entry_t      m_held[$];
        entry_t      m_ifid;
        bit          m_valid;
        bit          prev_rd;
        pred_mode = 2;
        do_reset();
        m_pc    = RST_PC;
        m_kill  = 1'b0;
        m_kill_addr = 32'h0;
        m_valid = 1'b0;
        prev_rd = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          rdy, st, rd, want_req, fetched, was_kill;
            logic [31:0] rpc, want_addr;
            entry_t      e;
            rdy = ($urandom_range(0, 2) != 0);
            st  = ($urandom_range(0, 2) == 0);
            rd  = !prev_rd && ($urandom_range(0, 13) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF8;
                1:       rpc = $urandom();
                default: rpc = {20'h0, $urandom_range(0, 1023) * 4};
            endcase
            imem_ready  = rdy;
            stall       = st;
            redirect    = rd;
            redirect_pc = rpc;
            prev_rd     = rd;

            want_req  = m_kill || (m_held.size() == 0);
            want_addr = m_kill ? m_kill_addr : m_pc;
            @(negedge clk);
            n_cmp++;
            if (imem_req !== want_req || imem_addr !== want_addr) begin
                n_fail++;
                $display("FAIL rand_imem[%0d]: req=%b addr=%h want req=%b addr=%h",
                         cyc, imem_req, imem_addr, want_req, want_addr);
            end
            if (!m_kill) begin
                n_cmp++;
                if (bp_pc !== m_pc || bp_pc_4 !== m_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL rand_bp[%0d]: bp_pc=%h pc4=%h want %h %h",
                             cyc, bp_pc, bp_pc_4, m_pc, m_pc + 32'd4);
                end
            end
            n_cmp++;
            if (IF_ID_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b want %b", cyc, IF_ID_valid, m_valid);
            end else if (m_valid) begin
                n_cmp++;
                if (IF_ID_inst !== m_ifid.inst || IF_ID_pc !== m_ifid.pc ||
                    IF_ID_pred_target !== m_ifid.tgt || IF_ID_pht_idx !== m_ifid.idx) begin
                    n_fail++;
                    $display("FAIL rand_ifid[%0d]: %h %h %h %h want %h %h %h %h", cyc,
                             IF_ID_inst, IF_ID_pc, IF_ID_pred_target, IF_ID_pht_idx,
                             m_ifid.inst, m_ifid.pc, m_ifid.tgt, m_ifid.idx);
                end
            end

            // Advance the model by one cycle of the fetch rules.
            was_kill = m_kill;
            fetched  = !was_kill && want_req && rdy;
            e = '{inst: mem_fn(m_pc), pc: m_pc, tgt: pred_fn(m_pc, pred_mode, jump_from, jump_to),
                  idx: pht_fn(m_pc)};
            if (was_kill && rdy) m_kill = 1'b0;
            if (rd) begin
                if (!was_kill && want_req && !rdy) begin
                    m_kill      = 1'b1;
                    m_kill_addr = m_pc;
                end
                m_pc    = rpc;
                m_valid = 1'b0;
                m_held.delete();
            end else begin
                if (fetched) m_pc = e.tgt;
                if (!st) begin
                    if (m_held.size() != 0) begin
                        m_ifid  = m_held.pop_front();
                        m_valid = 1'b1;
                    end else if (fetched) begin
                        m_ifid  = e;
                        m_valid = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end else if (fetched) begin
                    m_held.push_back(e);
                end
            end
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        pred_mode = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_predict();
        test_stall_skid();
        test_redirect_kill();
        test_redirect_stall();
        test_reset_mid_kill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
